data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory interface: services MemRead/MemWrite requests issued on mem_addr/mem_data_in, returns mem_data_out.
- Word-organised data RAM plus a small memory-mapped I/O window (LED register, free-running cycle counter).
- Configurable wait states and a one-cycle mem_ready pulse, so the same RAM serves single-cycle (WAIT_STATES=0) and stalling multi-cycle CPU variants.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_mmio_regs.sv | 38 +++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 tb/tb_data_mem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// MMIO register offsets and default I/O window base.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned WCNT_W = 4;
  localparam int unsigned LED_W  = 16;

  localparam logic [15:0] OFS_LED = 16'h0000;
  localparam logic [15:0] OFS_CYC = 16'h0004;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;

endpackage

// File: rtl/dmem_mmio_regs.sv
// Memory-mapped I/O registers: LED register and free-running cycle counter.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   i_led_we      write strobe for the LED register
//   i_led_wdata   LED write data
//   i_sel_cyc     read mux select: 1 = cycle counter, 0 = LED (zero-extended)
//   o_rd_data_c   combinational read data
//   o_led         LED register contents
module dmem_mmio_regs
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_led_we,
  input  logic [LED_W-1:0] i_led_wdata,
  input  logic             i_sel_cyc,
  output logic [31:0]      o_rd_data_c,
  output logic [LED_W-1:0] o_led
);

  logic [31:0]      r_cyc;
  logic [LED_W-1:0] r_led;

  // counter runs every cycle out of reset and wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
      r_led <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (i_led_we) r_led <= i_led_wdata;
    end
  end

  assign o_rd_data_c = i_sel_cyc ? r_cyc : {(32 - LED_W)'(0), r_led};
  assign o_led       = r_led;

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the CPU data-memory interface: word RAM plus an MMIO
// window, with configurable wait states and a one-cycle mem_ready pulse.
// Ports:
//   cpu_clk, reset          clock, async active-low reset
//   MemRead, MemWrite       request type (both set = error)
//   mem_addr, mem_data_in   byte address and write data
//   mem_data_out            read data (held between reads)
//   mem_ready               one-cycle response pulse
//   addr_err                request rejected (only with mem_ready)
//   led_out                 LED register contents
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEF
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_data_in,
  output logic [31:0]      mem_data_out,
  output logic             mem_ready,
  output logic             addr_err,
  output logic [LED_W-1:0] led_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t            r_state, w_next;
  logic [WCNT_W-1:0] r_wcnt;
  logic [31:0]       r_addr, r_wdata;
  logic              r_rd, r_wr;
  logic [31:0]       r_mem [DEPTH];

  logic              w_req, w_rd, w_wr, w_enter_resp;
  logic [31:0]       w_addr, w_wdata, w_rdata, w_mmio_rd;
  logic [ADDR_W-1:0] w_widx;
  logic              w_is_ram, w_is_mmio, w_hit_led, w_hit_cyc, w_err;
  logic              w_ram_we, w_led_we;

  assign w_req = MemRead | MemWrite;

  // with zero wait states the response edge is the accepting edge, so the
  // live request is used in IDLE and the latched copy everywhere else
  assign w_addr  = (r_state == IDLE) ? mem_addr    : r_addr;
  assign w_wdata = (r_state == IDLE) ? mem_data_in : r_wdata;
  assign w_rd    = (r_state == IDLE) ? MemRead     : r_rd;
  assign w_wr    = (r_state == IDLE) ? MemWrite    : r_wr;

  // state register
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (WAIT_STATES == 0) w_next = RESP;
          else                  w_next = WAIT;
        end
      end
      WAIT:    if (r_wcnt == WCNT_W'(1)) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == RESP);

  // request latch and wait counter
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else if (r_state == IDLE && w_req) begin
      r_wcnt  <= WCNT_W'(WAIT_STATES);
      r_addr  <= mem_addr;
      r_wdata <= mem_data_in;
      r_rd    <= MemRead;
      r_wr    <= MemWrite;
    end else if (r_state == WAIT) begin
      r_wcnt  <= r_wcnt - WCNT_W'(1);
    end
  end

  // address decode and error detection
  assign w_is_ram  = (w_addr[31:ADDR_W+2] == '0);
  assign w_is_mmio = (w_addr[31:16] == MMIO_BASE[31:16]);
  assign w_hit_led = w_is_mmio && (w_addr[15:0] == OFS_LED);
  assign w_hit_cyc = w_is_mmio && (w_addr[15:0] == OFS_CYC);
  assign w_err     = (|w_addr[1:0]) | (w_rd & w_wr)
                   | ~(w_is_ram | w_hit_led | w_hit_cyc);
  assign w_widx    = w_addr[ADDR_W+1:2];

  // reset gate keeps a zero-wait request from committing while held in reset
  assign w_ram_we = reset & w_enter_resp & w_wr & w_is_ram  & ~w_err;
  assign w_led_we = w_enter_resp & w_wr & w_hit_led & ~w_err;

  always_ff @(posedge cpu_clk) begin
    if (w_ram_we) r_mem[w_widx] <= w_wdata;
  end

  assign w_rdata = w_is_ram ? r_mem[w_widx] : w_mmio_rd;

  dmem_mmio_regs u_mmio (
    .clk         (cpu_clk),
    .rst_n       (reset),
    .i_led_we    (w_led_we),
    .i_led_wdata (w_wdata[LED_W-1:0]),
    .i_sel_cyc   (w_hit_cyc),
    .o_rd_data_c (w_mmio_rd),
    .o_led       (led_out)
  );

  // response outputs; write responses leave mem_data_out untouched
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      mem_ready    <= 1'b0;
      addr_err     <= 1'b0;
      mem_data_out <= '0;
    end else begin
      mem_ready <= w_enter_resp;
      addr_err  <= w_enter_resp & w_err;
      if (w_enter_resp) begin
        if (w_err)     mem_data_out <= '0;
        else if (w_rd) mem_data_out <= w_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (one and zero wait states),
// reference model with a scoreboard queue per instance and a separate monitor.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] dout  [2];
  logic        rdy   [2];
  logic        aerr  [2];
  logic [15:0] led   [2];

  data_mem_responder #(.ADDR_W(10), .WAIT_STATES(1), .MMIO_BASE(32'hFFFF_0000)) u_dut0 (
    .cpu_clk(clk), .reset(rst_n), .MemRead(rd[0]), .MemWrite(wr[0]),
    .mem_addr(addr[0]), .mem_data_in(wdata[0]), .mem_data_out(dout[0]),
    .mem_ready(rdy[0]), .addr_err(aerr[0]), .led_out(led[0]));

  data_mem_responder #(.ADDR_W(10), .WAIT_STATES(0), .MMIO_BASE(32'hFFFF_0000)) u_dut1 (
    .cpu_clk(clk), .reset(rst_n), .MemRead(rd[1]), .MemWrite(wr[1]),
    .mem_addr(addr[1]), .mem_data_in(wdata[1]), .mem_data_out(dout[1]),
    .mem_ready(rdy[1]), .addr_err(aerr[1]), .led_out(led[1]));

  typedef struct {
    logic        err;
    logic [31:0] data;
    logic [15:0] led;
    bit          is_cyc;
  } exp_t;

  exp_t        sb [2][$];
  logic [31:0] m_ram [2][1024];
  logic [15:0] m_led [2];
  logic [31:0] m_out [2];
  bit          b2b   [2];
  int          checks = 0;
  int          fails  = 0;
  int unsigned tb_edges = 0;
  exp_t        mon_e;

  // reference cycle count: edges seen since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_edges = 0;
    else        tb_edges = tb_edges + 1;
  end

  function automatic int ws(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference behaviour: decode, commit and expected response
  function automatic exp_t predict(int k, bit r, bit w, logic [31:0] a, logic [31:0] d);
    exp_t e;
    bit is_ram, is_led, is_cyc;
    is_ram = (a < 32'd4096);
    is_led = (a == 32'hFFFF_0000);
    is_cyc = (a == 32'hFFFF_0004);
    e.err = 1'b0;
    e.is_cyc = 1'b0;
    if (a[1:0] != 2'b00 || (r && w) || !(is_ram || is_led || is_cyc)) begin
      e.err = 1'b1;
      m_out[k] = 32'h0;
    end else if (w) begin
      if (is_ram)      m_ram[k][a[11:2]] = d;
      else if (is_led) m_led[k] = d[15:0];
    end else if (is_ram) begin
      m_out[k] = m_ram[k][a[11:2]];
    end else if (is_led) begin
      m_out[k] = {16'h0, m_led[k]};
    end else begin
      e.is_cyc = 1'b1;
    end
    e.data = m_out[k];
    e.led  = m_led[k];
    return e;
  endfunction

  // issue one request, wait (bounded) for its response, check the latency
  task automatic issue(int k, bit r, bit w, logic [31:0] a, logic [31:0] d);
    int n;
    int lat;
    sb[k].push_back(predict(k, r, w, a, d));
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d;
    lat = ws(k) + 1 + (b2b[k] ? 1 : 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[k] && n < 20);
    chk($sformatf("dut%0d_latency_%h", k, a), 32'(n), 32'(lat));
    rd[k] = 1'b0; wr[k] = 1'b0;
    b2b[k] = 1'b1;
    #1;
  endtask

  task automatic idle(int k, int n);
    repeat (n) @(negedge clk);
    b2b[k] = 1'b0;
  endtask

  task automatic rand_ops(int k, int n);
    logic [31:0] a;
    int sel, op;
    bit r, w;
    for (int i = 0; i < n; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: a = 32'($urandom_range(0, 15) * 4);
        4:          a = 32'h0000_0FFC;
        5:          a = 32'hFFFF_0000;
        6:          a = 32'hFFFF_0004;
        7:          a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        8:          a = 32'h0000_1000 + 32'($urandom_range(0, 255) * 4);
        default:    a = 32'hFFFF_0008;
      endcase
      op = int'($urandom_range(0, 7));
      r = (op <= 3) || (op == 7);
      w = (op >= 4);
      issue(k, r, w, a, $urandom);
      if ($urandom_range(0, 1) == 1) idle(k, int'($urandom_range(1, 3)));
    end
  endtask

  task automatic init_ram(int k);
    for (int i = 0; i < 16; i++) issue(k, 1'b0, 1'b1, 32'(i * 4), $urandom);
    issue(k, 1'b0, 1'b1, 32'h0000_0FFC, $urandom);
    idle(k, 1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n && rdy[k]) begin
        if (sb[k].size() == 0) begin
          checks++;
          fails++;
          $display("FAIL dut%0d_unexpected_ready: got mem_ready=1 expected 0", k);
        end else begin
          mon_e = sb[k].pop_front();
          if (mon_e.is_cyc) begin
            m_out[k] = 32'(tb_edges - 1);
            mon_e.data = m_out[k];
          end
          chk($sformatf("dut%0d_addr_err", k), 32'(aerr[k]), 32'(mon_e.err));
          chk($sformatf("dut%0d_data", k), dout[k], mon_e.data);
          chk($sformatf("dut%0d_led", k), 32'(led[k]), 32'(mon_e.led));
        end
      end else begin
        chk($sformatf("dut%0d_err_without_ready", k), 32'(aerr[k]), 32'h0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      m_led[k] = '0; m_out[k] = '0; b2b[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_rst_ready", k), 32'(rdy[k]), 32'h0);
      chk($sformatf("dut%0d_rst_dout", k), dout[k], 32'h0);
      chk($sformatf("dut%0d_rst_led", k), 32'(led[k]), 32'h0);
    end
    rst_n = 1'b1;
    idle(0, 1);

    // one wait state: directed cases
    init_ram(0);
    issue(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF); idle(0, 1);
    issue(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);         idle(0, 1);
    issue(0, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0001_A5A5); idle(0, 1);
    issue(0, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0);         idle(0, 1);
    issue(0, 1'b1, 1'b0, 32'hFFFF_0004, 32'h0);         idle(0, 7);
    issue(0, 1'b1, 1'b0, 32'hFFFF_0004, 32'h0);         idle(0, 1);
    issue(0, 1'b0, 1'b1, 32'hFFFF_0004, 32'h0000_1234); idle(0, 1);
    issue(0, 1'b1, 1'b0, 32'hFFFF_0004, 32'h0);         idle(0, 1);
    issue(0, 1'b1, 1'b0, 32'h0000_0013, 32'h0);
    issue(0, 1'b1, 1'b0, 32'h0010_0000, 32'h0);
    issue(0, 1'b1, 1'b1, 32'h0000_0000, 32'h1111_2222);
    issue(0, 1'b0, 1'b1, 32'hFFFF_0008, 32'h3333_4444);
    issue(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);         idle(0, 1);
    rand_ops(0, 60);
    idle(0, 2);

    // zero wait states: back-to-back held reads, then random traffic
    idle(1, 1);
    init_ram(1);
    issue(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    issue(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    issue(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    issue(1, 1'b1, 1'b0, 32'hFFFF_0004, 32'h0);         idle(1, 1);
    issue(1, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_5A5A); idle(1, 1);
    rand_ops(1, 60);
    idle(1, 2);

    // reset while a write to 0x20 sits in the wait state
    idle(0, 1);
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h0000_0020; wdata[0] = 32'h0000_0055;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    wr[0] = 1'b0;
    chk("dut0_abort_ready", 32'(rdy[0]), 32'h0);
    chk("dut0_abort_led", 32'(led[0]), 32'h0);
    chk("dut1_abort_led", 32'(led[1]), 32'h0);
    for (int k = 0; k < 2; k++) begin
      m_led[k] = '0; m_out[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("dut0_post_reset_ready", 32'(rdy[0]), 32'h0);
    idle(0, 0);
    issue(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0); idle(0, 1);
    issue(0, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0); idle(0, 1);
    issue(0, 1'b1, 1'b0, 32'hFFFF_0004, 32'h0); idle(0, 2);
    idle(1, 0);
    issue(1, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0); idle(1, 2);

    chk("dut0_sb_drained", 32'(sb[0].size()), 32'h0);
    chk("dut1_sb_drained", 32'(sb[1].size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // overall time bound
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
